// File: rtl/multicycle_control.sv
// Main control FSM of the multicycle RISC-V core: sequences each instruction and drives datapath selects/enables.
// Optional feature macro: MC_ITYPE_EN (builds the EXECI state so opcode 0010011 executes instead of trapping as illegal).
module multicycle_control #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [6:0]       opcode,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             pc_write,
    output logic             ir_write,
    output logic             adr_src,
    output logic             mem_write,
    output logic             reg_write,
    output logic [1:0]       alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [1:0]       alu_op,
    output logic [1:0]       result_src,
    output logic             illegal_op,
    output logic             retire,
    output logic [CNT_W-1:0] instr_count
);

    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_BEQ  = 7'b1100011;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_ALUWB    = 4'd8,
        S_BEQ      = 4'd9
`ifdef MC_ITYPE_EN
        ,S_EXECI   = 4'd7
`endif
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic             w_pc_write;
    logic             w_ir_write;
    logic             w_adr_src;
    logic             w_mem_write;
    logic             w_reg_write;
    logic [1:0]       w_alu_src_a;
    logic [1:0]       w_alu_src_b;
    logic [1:0]       w_alu_op;
    logic [1:0]       w_result_src;
    logic             w_illegal_op;
    logic             w_retire;
    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next       = S_FETCH;
        w_pc_write   = 1'b0;
        w_ir_write   = 1'b0;
        w_adr_src    = 1'b0;
        w_mem_write  = 1'b0;
        w_reg_write  = 1'b0;
        w_alu_src_a  = 2'b00;
        w_alu_src_b  = 2'b00;
        w_alu_op     = 2'b00;
        w_result_src = 2'b00;
        w_illegal_op = 1'b0;
        w_retire     = 1'b0;
        case (r_state)
            S_FETCH: begin
                w_alu_src_b  = 2'b10;
                w_result_src = 2'b10;
                w_ir_write   = mem_ready;
                w_pc_write   = mem_ready;
                w_next       = mem_ready ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                // ALU precomputes the branch target (oldPC + imm) while the opcode is decoded
                w_alu_src_a = 2'b01;
                w_alu_src_b = 2'b01;
                case (opcode)
                    OP_LW, OP_SW: w_next = S_MEMADR;
                    OP_R:         w_next = S_EXECR;
`ifdef MC_ITYPE_EN
                    OP_I:         w_next = S_EXECI;
`endif
                    OP_BEQ:       w_next = S_BEQ;
                    default: begin
                        w_illegal_op = 1'b1;
                        w_next       = S_FETCH;
                    end
                endcase
            end
            S_MEMADR: begin
                w_alu_src_a = 2'b10;
                w_alu_src_b = 2'b01;
                w_next      = (opcode == OP_LW) ? S_MEMREAD : S_MEMWRITE;
            end
            S_MEMREAD: begin
                w_adr_src = 1'b1;
                w_next    = mem_ready ? S_MEMWB : S_MEMREAD;
            end
            S_MEMWB: begin
                w_result_src = 2'b01;
                w_reg_write  = 1'b1;
                w_retire     = 1'b1;
            end
            S_MEMWRITE: begin
                w_adr_src   = 1'b1;
                w_mem_write = 1'b1;
                w_retire    = mem_ready;
                w_next      = mem_ready ? S_FETCH : S_MEMWRITE;
            end
            S_EXECR: begin
                w_alu_src_a = 2'b10;
                w_alu_op    = 2'b10;
                w_next      = S_ALUWB;
            end
`ifdef MC_ITYPE_EN
            S_EXECI: begin
                w_alu_src_a = 2'b10;
                w_alu_src_b = 2'b01;
                w_alu_op    = 2'b10;
                w_next      = S_ALUWB;
            end
`endif
            S_ALUWB: begin
                w_reg_write = 1'b1;
                w_retire    = 1'b1;
            end
            S_BEQ: begin
                w_alu_src_a = 2'b10;
                w_alu_op    = 2'b01;
                w_pc_write  = zero;
                w_retire    = 1'b1;
            end
            default: ;
        endcase
        // Enables and pulses are suppressed for the whole reset interval, not just after the edge
        if (reset) begin
            w_pc_write   = 1'b0;
            w_ir_write   = 1'b0;
            w_mem_write  = 1'b0;
            w_reg_write  = 1'b0;
            w_illegal_op = 1'b0;
            w_retire     = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count <= '0;
        end else if (w_retire) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

    assign pc_write    = w_pc_write;
    assign ir_write    = w_ir_write;
    assign adr_src     = w_adr_src;
    assign mem_write   = w_mem_write;
    assign reg_write   = w_reg_write;
    assign alu_src_a   = w_alu_src_a;
    assign alu_src_b   = w_alu_src_b;
    assign alu_op      = w_alu_op;
    assign result_src  = w_result_src;
    assign illegal_op  = w_illegal_op;
    assign retire      = w_retire;
    assign instr_count = r_count;

endmodule

// File: doc/multicycle_control.md
# multicycle_control

Main control FSM for the multicycle RISC-V core. It sequences every instruction through fetch, decode, execute, memory and writeback states. It drives the datapath multiplexer selects and write enables, and produces the 2-bit `alu_op` consumed directly by the ALU control stage, which combines it with the funct field to pick the ALU operation. It sits between the instruction register (opcode) and the ALU control and datapath.

## Interface
Parameters:
- `CNT_W`, default 32: width of the retired-instruction counter.

Ports:
- `clk`, input, 1: single clock; all state changes on the rising edge.
- `reset`, input, 1: asynchronous, active-high.
- `opcode`, input, 7: instr[6:0] from the instruction register.
- `zero`, input, 1: ALU zero flag.
- `mem_ready`, input, 1: memory has completed the current access this cycle.
- `pc_write`, output, 1: PC register load enable.
- `ir_write`, output, 1: instruction register load enable.
- `adr_src`, output, 1: memory address select; 0 = PC, 1 = ALUOut.
- `mem_write`, output, 1: memory write request.
- `reg_write`, output, 1: register file write enable.
- `alu_src_a`, output, 2: ALU A input select; 00 = PC, 01 = oldPC, 10 = rs1.
- `alu_src_b`, output, 2: ALU B input select; 00 = rs2, 01 = imm, 10 = constant 4.
- `alu_op`, output, 2: 00 = add, 01 = subtract/compare, 10 = decode funct.
- `result_src`, output, 2: result select; 00 = ALUOut, 01 = memory data, 10 = ALU result.
- `illegal_op`, output, 1: one-cycle pulse when DECODE sees an unsupported opcode.
- `retire`, output, 1: one-cycle pulse on the last cycle of each completed instruction.
- `instr_count`, output, CNT_W: count of retired instructions.

## Operation
- Moore FSM with a 4-bit state register. Outputs decode from the state, except that `pc_write` and `ir_write` are gated by `mem_ready` and `zero` as noted below. All outputs not listed for a state are 0.
- FETCH (0): `adr_src`=0, `alu_src_a`=00, `alu_src_b`=10, `alu_op`=00, `result_src`=10.
  - `ir_write` and `pc_write` equal `mem_ready`.
  - Stay in FETCH while `mem_ready`=0; otherwise go to DECODE.
- DECODE (1): `alu_src_a`=01, `alu_src_b`=01, `alu_op`=00 (computes the branch target). Next state by opcode:
  - 0000011 (lw) or 0100011 (sw) -> MEMADR.
  - 0110011 (R-type) -> EXECR.
  - 0010011 (I-type) -> EXECI.
  - 1100011 (beq) -> BEQ.
  - Anything else -> FETCH, with `illegal_op`=1 for this cycle.
- MEMADR (2): `alu_src_a`=10, `alu_src_b`=01, `alu_op`=00. Goes to MEMREAD for lw or MEMWRITE for sw; the opcode is held by the IR.
- MEMREAD (3): `adr_src`=1, `result_src`=00. Waits for `mem_ready`=1, then goes to MEMWB.
- MEMWB (4): `result_src`=01, `reg_write`=1, `retire`=1. Goes to FETCH.
- MEMWRITE (5): `adr_src`=1, `mem_write`=1, held until `mem_ready`=1. In the `mem_ready` cycle `retire`=1 and the FSM goes to FETCH.
- EXECR (6): `alu_src_a`=10, `alu_src_b`=00, `alu_op`=10. Goes to ALUWB.
- EXECI (7): `alu_src_a`=10, `alu_src_b`=01, `alu_op`=10. Goes to ALUWB.
- ALUWB (8): `result_src`=00, `reg_write`=1, `retire`=1. Goes to FETCH.
- BEQ (9): `alu_src_a`=10, `alu_src_b`=00, `alu_op`=01, `result_src`=00, `pc_write`=`zero`, `retire`=1. Goes to FETCH.
- Unused encodings 10–15 go to FETCH on the next edge with all outputs 0.
- `instr_count` increments by 1 on every clock edge where `retire`=1. It wraps modulo 2^CNT_W with no saturation.

## Timing
- Reset value: state = FETCH and `instr_count`=0.
  - While `reset`=1, `pc_write`, `ir_write`, `mem_write`, `reg_write`, `illegal_op` and `retire` are forced to 0.
  - Select outputs show the FETCH values.
- Reset asserted mid-instruction aborts it immediately. No retire occurs and the counter clears.
- Cycle counts with zero-wait memory (`mem_ready` held at 1):
  - lw: 5 cycles.
  - sw: 4 cycles.
  - R-type and I-type: 4 cycles.
  - beq: 3 cycles.
- Each cycle with `mem_ready`=0 in FETCH, MEMREAD or MEMWRITE adds exactly one cycle. Outputs stay stable during the stall.
- An illegal opcode costs 2 cycles (FETCH, DECODE) and produces no retire.

## Configuration
- `MC_ITYPE_EN`:
  - Defined: opcode 0010011 decodes to EXECI as above.
  - Undefined: the EXECI state is not built. Opcode 0010011 is treated as illegal (`illegal_op` pulse, return to FETCH).

## Test plan
- Reset then release with `mem_ready`=1, opcode 0110011 -> states 0,1,6,8,0; `alu_op`=10 in EXECR; `reg_write`=1 only in ALUWB; `instr_count`=1.
- lw (0000011) with `mem_ready` low for 2 cycles in MEMREAD -> 7 cycles total; `result_src`=01 with `reg_write`=1 in MEMWB.
- beq (1100011) with `zero`=1, then again with `zero`=0 -> `pc_write`=1 in the BEQ cycle only for the first; `alu_op`=01; `instr_count`=2.
- Opcode 1111111 -> `illegal_op` pulses once in DECODE, FSM returns to FETCH, `instr_count` unchanged.
- sw with `reset` asserted during MEMWRITE -> `mem_write` drops asynchronously, state = FETCH, `instr_count`=0.
- opcode 0010011 -> with `MC_ITYPE_EN` defined, EXECI with `alu_src_b`=01 and 4 cycles; without it, an `illegal_op` pulse.
